// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN calculator.
// State encoding, error codes and data widths.
package rpn_pkg;
    localparam int LARGURA = 8;
    localparam int LARGURA_OP = 3;

    typedef enum logic {
        OCIOSO,
        ESPERA_ULA
    } estado_t;

    localparam logic [1:0] ERRO_OK    = 2'b00;
    localparam logic [1:0] ERRO_CHEIA = 2'b01;
    localparam logic [1:0] ERRO_VAZIA = 2'b10;
    localparam logic [1:0] ERRO_ULA   = 2'b11;
endpackage

// File: rtl/pilha_rpn.sv
// Shift-register operand stack; entry 0 is the top.
// Unused entries are always 0, so top/second read 0 when absent.
module pilha_rpn
    import rpn_pkg::*;
#(
    parameter int PROFUNDIDADE = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic                              pop2_push,
    input  logic                              clear,
    input  logic [LARGURA-1:0]                dado,
    output logic [LARGURA-1:0]                topo,
    output logic [LARGURA-1:0]                segundo,
    output logic [$clog2(PROFUNDIDADE+1)-1:0] nivel
);
    localparam int NW = $clog2(PROFUNDIDADE + 1);

    logic [LARGURA-1:0] mem [PROFUNDIDADE];

    // Shift down on push, shift up on pop2_push, zero on clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < PROFUNDIDADE; i++) mem[i] <= '0;
            nivel <= '0;
        end else if (push && nivel != NW'(PROFUNDIDADE)) begin
            mem[0] <= dado;
            for (int i = 1; i < PROFUNDIDADE; i++) mem[i] <= mem[i-1];
            nivel <= nivel + NW'(1);
        end else if (pop2_push && nivel >= NW'(2)) begin
            mem[0] <= dado;
            for (int i = 1; i < PROFUNDIDADE - 1; i++) mem[i] <= mem[i+1];
            mem[PROFUNDIDADE-1] <= '0;
            nivel <= nivel - NW'(1);
        end
    end

    assign topo    = mem[0];
    assign segundo = mem[1];
endmodule

// File: rtl/controlador_rpn.sv
// RPN sequencing controller: stack commands, ALU handshake,
// timeout and error reporting.
module controlador_rpn
    import rpn_pkg::*;
#(
    parameter int PROFUNDIDADE = 4,
    parameter int TIMEOUT_ULA  = 15
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [LARGURA-1:0]                entrada,
    input  logic [LARGURA_OP-1:0]             operacao,
    input  logic                              entrada_numero,
    input  logic                              entrada_operacao,
    input  logic                              limpar,
    output logic [LARGURA-1:0]                ula_a,
    output logic [LARGURA-1:0]                ula_b,
    output logic [LARGURA_OP-1:0]             ula_op,
    output logic                              ula_req,
    input  logic                              ula_ack,
    input  logic [LARGURA-1:0]                ula_resultado,
    input  logic                              ula_erro,
    output logic [LARGURA-1:0]                display_a,
    output logic [LARGURA-1:0]                display_b,
    output logic [$clog2(PROFUNDIDADE+1)-1:0] nivel,
    output logic                              pilha_vazia,
    output logic                              pilha_cheia,
    output logic                              ocupado,
    output logic [1:0]                        erro
);
    localparam int NW = $clog2(PROFUNDIDADE + 1);
    localparam int CW = $clog2(TIMEOUT_ULA + 1);

    estado_t            estado, estado_prox;
    logic [CW-1:0]      cont;
    logic               expirou;
    logic               s_push, s_pop2, s_clear;
    logic [LARGURA-1:0] s_dado;
    logic               tem_dois;

    assign pilha_vazia = (nivel == '0);
    assign pilha_cheia = (nivel == NW'(PROFUNDIDADE));
    assign tem_dois    = (nivel >= NW'(2));
    assign ocupado     = (estado != OCIOSO);
    assign expirou     = (cont == CW'(TIMEOUT_ULA - 1));

    pilha_rpn #(
        .PROFUNDIDADE(PROFUNDIDADE)
    ) u_pilha (
        .clk      (clk),
        .rst      (rst),
        .push     (s_push),
        .pop2_push(s_pop2),
        .clear    (s_clear),
        .dado     (s_dado),
        .topo     (display_a),
        .segundo  (display_b),
        .nivel    (nivel)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= estado_prox;
    end

    // Next state and stack commands; limpar beats everything.
    always_comb begin
        estado_prox = estado;
        s_push      = 1'b0;
        s_pop2      = 1'b0;
        s_clear     = 1'b0;
        s_dado      = entrada;
        if (limpar) begin
            s_clear     = 1'b1;
            estado_prox = OCIOSO;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (entrada_numero) begin
                        s_push = !pilha_cheia;
                    end else if (entrada_operacao && tem_dois) begin
                        estado_prox = ESPERA_ULA;
                    end
                end
                ESPERA_ULA: begin
                    if (ula_ack) begin
                        s_pop2      = !ula_erro;
                        s_dado      = ula_resultado;
                        estado_prox = OCIOSO;
                    end else if (expirou) begin
                        estado_prox = OCIOSO;
                    end
                end
                default: estado_prox = OCIOSO;
            endcase
        end
    end

    // Operand latch, request, timeout counter and error status.
    always_ff @(posedge clk) begin
        if (rst) begin
            ula_a   <= '0;
            ula_b   <= '0;
            ula_op  <= '0;
            ula_req <= 1'b0;
            cont    <= '0;
            erro    <= ERRO_OK;
        end else if (limpar) begin
            ula_req <= 1'b0;
            cont    <= '0;
            erro    <= ERRO_OK;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (entrada_numero) begin
                        erro <= pilha_cheia ? ERRO_CHEIA : ERRO_OK;
                    end else if (entrada_operacao) begin
                        if (!tem_dois) begin
                            erro <= ERRO_VAZIA;
                        end else begin
                            ula_a   <= display_b;
                            ula_b   <= display_a;
                            ula_op  <= operacao;
                            ula_req <= 1'b1;
                            cont    <= '0;
                        end
                    end
                end
                ESPERA_ULA: begin
                    if (ula_ack) begin
                        ula_req <= 1'b0;
                        erro    <= ula_erro ? ERRO_ULA : ERRO_OK;
                    end else if (expirou) begin
                        ula_req <= 1'b0;
                        erro    <= ERRO_ULA;
                    end else begin
                        cont <= cont + CW'(1);
                    end
                end
                default: ula_req <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_controlador_rpn.sv
// Bench for controlador_rpn: directed plan followed by random
// command mix against a queue-based stack model.
module tb_controlador_rpn;
    localparam int P = 4;
    localparam int T = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] entrada = '0;
    logic [2:0] operacao = '0;
    logic       entrada_numero = 1'b0;
    logic       entrada_operacao = 1'b0;
    logic       limpar = 1'b0;
    logic [7:0] ula_a, ula_b;
    logic [2:0] ula_op;
    logic       ula_req;
    logic       ula_ack = 1'b0;
    logic [7:0] ula_resultado = '0;
    logic       ula_erro = 1'b0;
    logic [7:0] display_a, display_b;
    logic [2:0] nivel;
    logic       pilha_vazia, pilha_cheia, ocupado;
    logic [1:0] erro;

    int checks = 0;
    int errors = 0;

    int         pilha[$];
    logic [1:0] m_erro = 2'b00;

    controlador_rpn #(.PROFUNDIDADE(P), .TIMEOUT_ULA(T)) dut (
        .clk(clk), .rst(rst), .entrada(entrada), .operacao(operacao),
        .entrada_numero(entrada_numero), .entrada_operacao(entrada_operacao),
        .limpar(limpar), .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
        .ula_req(ula_req), .ula_ack(ula_ack), .ula_resultado(ula_resultado),
        .ula_erro(ula_erro), .display_a(display_a), .display_b(display_b),
        .nivel(nivel), .pilha_vazia(pilha_vazia), .pilha_cheia(pilha_cheia),
        .ocupado(ocupado), .erro(erro)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible status output against the model.
    task automatic confere(input string tag);
        int da, db;
        da = (pilha.size() > 0) ? pilha[0] : 0;
        db = (pilha.size() > 1) ? pilha[1] : 0;
        chk({tag, "_nivel"}, 32'(nivel), 32'(pilha.size()));
        chk({tag, "_disp_a"}, 32'(display_a), 32'(da));
        chk({tag, "_disp_b"}, 32'(display_b), 32'(db));
        chk({tag, "_vazia"}, 32'(pilha_vazia), 32'(pilha.size() == 0));
        chk({tag, "_cheia"}, 32'(pilha_cheia), 32'(pilha.size() == P));
        chk({tag, "_erro"}, 32'(erro), 32'(m_erro));
        chk({tag, "_ocupado"}, 32'(ocupado), 0);
        chk({tag, "_req"}, 32'(ula_req), 0);
    endtask

    task automatic do_push(input logic [7:0] v, input logic com_op);
        entrada = v;
        entrada_numero = 1'b1;
        entrada_operacao = com_op;
        tick();
        entrada_numero = 1'b0;
        entrada_operacao = 1'b0;
        if (pilha.size() < P) begin
            pilha.push_front(int'(v));
            m_erro = 2'b00;
        end else begin
            m_erro = 2'b01;
        end
        confere("push");
    endtask

    task automatic do_limpar();
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
        pilha.delete();
        m_erro = 2'b00;
        confere("limpar");
    endtask

    // atraso >= T means no ack; abortar 1 = limpar, 2 = rst at cycle 2.
    task automatic do_op(input logic [2:0] op, input int atraso,
                         input logic [7:0] res, input logic er,
                         input int abortar);
        int  a, b;
        bit  feito;
        entrada_operacao = 1'b1;
        operacao = op;
        tick();
        entrada_operacao = 1'b0;
        operacao = 3'($urandom);
        if (pilha.size() < 2) begin
            m_erro = 2'b10;
            confere("op_vazia");
            return;
        end
        a = pilha[1];
        b = pilha[0];
        chk("req_on", 32'(ula_req), 1);
        chk("ula_a", 32'(ula_a), 32'(a));
        chk("ula_b", 32'(ula_b), 32'(b));
        chk("ula_op", 32'(ula_op), 32'(op));
        chk("ocupado_on", 32'(ocupado), 1);
        feito = 1'b0;
        for (int c = 0; c < T && !feito; c++) begin
            entrada_numero = 1'($urandom_range(0, 1));
            entrada = 8'($urandom);
            if (abortar != 0 && c == 2) begin
                if (abortar == 1) limpar = 1'b1;
                else rst = 1'b1;
                tick();
                limpar = 1'b0;
                rst = 1'b0;
                entrada_numero = 1'b0;
                pilha.delete();
                m_erro = 2'b00;
                confere(abortar == 1 ? "abort_limpar" : "abort_rst");
                if (abortar == 2) begin
                    chk("rst_ula_a", 32'(ula_a), 0);
                    chk("rst_ula_op", 32'(ula_op), 0);
                end
                ula_ack = 1'b1;
                ula_resultado = 8'($urandom);
                tick();
                ula_ack = 1'b0;
                confere("stray_ack");
                return;
            end
            if (c == atraso) begin
                ula_ack = 1'b1;
                ula_resultado = res;
                ula_erro = er;
                feito = 1'b1;
            end
            tick();
            ula_ack = 1'b0;
            ula_erro = 1'b0;
            entrada_numero = 1'b0;
            if (!feito && c < T - 1) begin
                chk("req_hold", 32'(ula_req), 1);
                chk("a_hold", 32'(ula_a), 32'(a));
                chk("b_hold", 32'(ula_b), 32'(b));
                chk("op_hold", 32'(ula_op), 32'(op));
            end
        end
        if (feito && !er) begin
            void'(pilha.pop_front());
            void'(pilha.pop_front());
            pilha.push_front(int'(res));
            m_erro = 2'b00;
        end else begin
            m_erro = 2'b11;
        end
        confere("fim_op");
    endtask

    initial begin
        int r, d;
        tick();
        tick();
        rst = 1'b0;
        confere("reset");
        chk("reset_ula_a", 32'(ula_a), 0);
        chk("reset_ula_b", 32'(ula_b), 0);
        chk("reset_ula_op", 32'(ula_op), 0);

        do_push(8'd5, 1'b0);
        do_push(8'd7, 1'b0);
        do_push(8'd9, 1'b0);

        do_limpar();
        do_push(8'd12, 1'b0);
        do_push(8'd3, 1'b0);
        do_op(3'b001, 3, 8'd15, 1'b0, 0);

        do_limpar();
        for (int i = 0; i < 5; i++) do_push(8'(i + 1), 1'b0);
        do_limpar();
        do_push(8'd1, 1'b0);
        do_op(3'b010, 0, 8'd0, 1'b0, 0);

        do_push(8'd2, 1'b0);
        do_op(3'b011, 1, 8'd44, 1'b1, 0);
        do_op(3'b100, 100, 8'd0, 1'b0, 0);
        do_op(3'b101, 0, 8'd77, 1'b0, 0);

        do_push(8'd20, 1'b0);
        do_push(8'd30, 1'b1);
        do_op(3'b110, T - 1, 8'd50, 1'b0, 0);

        do_push(8'd8, 1'b0);
        do_op(3'b111, 100, 8'd0, 1'b0, 1);
        do_push(8'd4, 1'b0);
        do_push(8'd6, 1'b0);
        do_op(3'b000, 100, 8'd0, 1'b0, 2);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                do_push(8'($urandom), 1'($urandom_range(0, 1)));
            end else if (r < 9) begin
                d = $urandom_range(0, T + 2);
                do_op(3'($urandom), d, 8'($urandom),
                      1'($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 9) == 0 && d > 2) ? 1 : 0);
            end else begin
                do_limpar();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/controlador_rpn.md
# controlador_rpn

Sequencing controller for the RPN calculator. It owns a register stack of `PROFUNDIDADE` 8-bit entries, accepts number and operation commands, and pops two operands to the ALU through a req/ack handshake. It then pushes the ALU result back onto the stack and reports stack level and errors. It sits between the user-input front end and the ALU, and drives the display outputs.

## Interface
- `PROFUNDIDADE`, default 4: stack depth in entries. Must be at least 2.
- `TIMEOUT_ULA`, default 15: maximum number of cycles `ula_req` may wait for `ula_ack`.
- `clk` input, 1 bit: single clock. All logic uses the rising edge.
- `rst` input, 1 bit: reset. Synchronous and active-high.
- `entrada` input, 8 bits: number to push.
- `operacao` input, 3 bits: ALU opcode. Passed through unchanged; all 8 codes are binary operations.
- `entrada_numero` input, 1 bit: one-cycle push command.
- `entrada_operacao` input, 1 bit: one-cycle operate command.
- `limpar` input, 1 bit: clears the stack and aborts any operation in progress.
- `ula_a` output, 8 bits: first operand, the older entry (second from top).
- `ula_b` output, 8 bits: second operand, the top of stack.
- `ula_op` output, 3 bits: latched opcode.
- `ula_req` output, 1 bit: operation request.
- `ula_ack` input, 1 bit: ALU done. Qualifies `ula_resultado` and `ula_erro`.
- `ula_resultado` input, 8 bits: ALU result.
- `ula_erro` input, 1 bit: ALU fault, e.g. divide by zero.
- `display_a` output, 8 bits: top of stack. 0 when empty.
- `display_b` output, 8 bits: second entry. 0 when fewer than 2 entries.
- `nivel` output, `$clog2(PROFUNDIDADE+1)` bits: number of occupied entries.
- `pilha_vazia` output, 1 bit: high when `nivel` = 0.
- `pilha_cheia` output, 1 bit: high when `nivel` = `PROFUNDIDADE`.
- `ocupado` output, 1 bit: high while not in OCIOSO.
- `erro` output, 2 bits: status of the last command. 00 ok, 01 overflow, 10 underflow, 11 ALU fault or timeout.

## Operation
- FSM states: OCIOSO and ESPERA_ULA.
- Command priority in OCIOSO, highest first: `limpar`, then `entrada_numero`, then `entrada_operacao`. A lower-priority command in the same cycle is dropped.
- **Push**, OCIOSO with `entrada_numero`:
  - Not full: `entrada` becomes the top, older entries shift down, `nivel` increments, `erro` becomes 00.
  - Full: stack unchanged, `erro` becomes 01.
- **Operate**, OCIOSO with `entrada_operacao`:
  - `nivel` below 2: stack unchanged, `erro` becomes 10, stay in OCIOSO.
  - Otherwise: register `ula_a` = second, `ula_b` = top, `ula_op` = `operacao`; assert `ula_req`; go to ESPERA_ULA.
- **ESPERA_ULA**:
  - `ula_req`, `ula_a`, `ula_b` and `ula_op` are held stable.
  - `entrada_numero` and `entrada_operacao` are ignored and not queued.
- **Completion**, `ula_ack` high in ESPERA_ULA:
  - `ula_erro` = 0: pop 2, push `ula_resultado`. `nivel` decrements by 1, `erro` becomes 00.
  - `ula_erro` = 1: stack unchanged, `erro` becomes 11.
  - In both cases deassert `ula_req` and return to OCIOSO.
- **Timeout**: `ula_ack` absent for `TIMEOUT_ULA` cycles. Stack unchanged, `erro` becomes 11, return to OCIOSO.
- **`limpar`**, any state: `nivel` becomes 0, all entries 0, `ula_req` becomes 0, `erro` becomes 00, state becomes OCIOSO.
- `ula_ack` outside ESPERA_ULA is ignored.
- `erro` holds its value until the next accepted command or `limpar`.

## Timing
- Reset, and `limpar`, take effect at the next rising edge. After reset:
  - all stack entries 0, `nivel` 0;
  - `display_a`, `display_b`, `ula_a`, `ula_b` 0; `ula_op` 0; `ula_req` 0;
  - `erro` 00, `ocupado` 0, `pilha_vazia` 1, `pilha_cheia` 0;
  - state OCIOSO.
- Reset during ESPERA_ULA drops `ula_req` at that edge. A late `ula_ack` is then ignored.
- Push: `display_a` and `nivel` update at the edge that samples the command. Latency is 1 cycle.
- Operate: `ula_req` and operands are valid in the cycle after the command edge.
  - `ula_ack` is sampled from that cycle onward. The earliest ack is in the first `ula_req` cycle.
  - The stack update and `ocupado` falling both occur at the ack edge.
  - Minimum command-to-result latency is 2 edges.
- Timeout counter:
  - Clears on entry to ESPERA_ULA and counts each cycle without ack.
  - At count `TIMEOUT_ULA` the FSM aborts at that edge.
  - `ula_ack` arriving in the same cycle as expiry wins.
- All outputs are registered.

## Structure
- Package `rpn_pkg`:
  - state enum (OCIOSO, ESPERA_ULA);
  - error code constants ERRO_OK, ERRO_CHEIA, ERRO_VAZIA, ERRO_ULA;
  - `LARGURA` = 8;
  - opcode width = 3.
- Sub-module `pilha_rpn`: parameterised shift-register stack.
  - Controls: push, pop2_push (replace the top two entries with one), clear.
  - Outputs: top, second, level.
- `controlador_rpn` contains the FSM, timeout counter, operand/opcode registers and error register.

## Test plan
- Reset, then push 5, 7, 9 → `nivel` = 3, `display_a` = 9, `display_b` = 7, `erro` = 00.
- Push 12 then 3, operate opcode 3'b001; ALU acks after 3 cycles with result 15 →
  - `ula_a` = 12, `ula_b` = 3, `ula_op` = 001 while `ula_req` is high;
  - then `nivel` = 1, `display_a` = 15.
- With `PROFUNDIDADE` = 4, five pushes → fifth push leaves the stack unchanged, `erro` = 01, `pilha_cheia` = 1. One operate with `nivel` = 1 → `erro` = 10.
- Operate with ack and `ula_erro` = 1 → stack unchanged, `erro` = 11. Separately, never ack → `ula_req` drops after 15 cycles, `erro` = 11.
- Assert `entrada_numero` during ESPERA_ULA → ignored. Assert `entrada_numero` and `entrada_operacao` together in OCIOSO → push only.
- Assert `limpar`, and separately `rst`, mid-ESPERA_ULA → next edge: `ula_req` = 0, `nivel` = 0, `ocupado` = 0. A later stray `ula_ack` has no effect.
